// File: rtl/sha_2_pkg.sv
// Round constants, initial hash values, Sigma/sigma helpers and FSM encoding
// shared by the iterative SHA-2 core and its round datapath.
package sha_2_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Initial hash values packed {H0..H7}, H0 in the MSBs to match the Hash port.
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] big_sigma0_32(input logic [31:0] x);
        return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1_32(input logic [31:0] x);
        return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0_32(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1_32(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [63:0] big_sigma0_64(input logic [63:0] x);
        return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
    endfunction

    function automatic logic [63:0] big_sigma1_64(input logic [63:0] x);
        return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
    endfunction

    function automatic logic [63:0] small_sigma0_64(input logic [63:0] x);
        return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] small_sigma1_64(input logic [63:0] x);
        return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    endfunction

endpackage

// File: rtl/sha_2_round.sv
// Combinational single SHA-2 compression round: {a..h}, W[t], K[t] in, next {a..h} out.
module sha_2_round
    import sha_2_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [8*WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0]   i_w,
    input  logic [WIDTH-1:0]   i_k,
    output logic [8*WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [WIDTH-1:0] w_bs0, w_bs1, w_ch, w_maj, w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    if (WIDTH == 32) begin : g_w32
        assign w_bs0 = big_sigma0_32(w_a);
        assign w_bs1 = big_sigma1_32(w_e);
    end else begin : g_w64
        assign w_bs0 = big_sigma0_64(w_a);
        assign w_bs1 = big_sigma1_64(w_e);
    end

    assign w_ch  = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1  = w_h + w_bs1 + w_ch + i_k + i_w;
    assign w_t2  = w_bs0 + w_maj;

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha_2.sv
// Iterative SHA-2 compression core: one round per clock, chains blocks of a message.
// WIDTH=32 implements SHA-224/256, WIDTH=64 implements SHA-384/512.
module sha_2
    import sha_2_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*WIDTH-1:0]   Data,
    input  logic                  First,
    input  logic                  Mode,
    input  logic                  In_valid,
    output logic                  In_ready,
    output logic [8*WIDTH-1:0]    Hash,
    output logic                  Out_valid
);

    localparam int unsigned ROUNDS = (WIDTH == 32) ? 64 : 80;
    localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("sha_2: WIDTH must be 32 or 64");
    end

    state_e             r_state;
    logic [6:0]         r_t;
    logic [WIDTH-1:0]   r_buf [16];
    logic [8*WIDTH-1:0] r_work;
    logic [8*WIDTH-1:0] r_chain;
    logic [8*WIDTH-1:0] r_hash;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_accept;
    logic [3:0]         w_i2, w_i7, w_i15, w_i16;
    logic [WIDTH-1:0]   w_k, w_sched, w_w;
    logic [8*WIDTH-1:0] w_iv, w_h_init, w_next, w_sum;

    assign w_accept = In_valid && r_in_ready;

    // Schedule lives in a 16-entry ring: slot t[3:0] holds W[t-16] until overwritten by W[t].
    assign w_i16 = r_t[3:0];
    assign w_i15 = r_t[3:0] + 4'd1;
    assign w_i7  = r_t[3:0] - 4'd7;
    assign w_i2  = r_t[3:0] - 4'd2;

    if (WIDTH == 32) begin : g_w32
        assign w_k     = K256[r_t[5:0]];
        assign w_sched = small_sigma1_32(r_buf[w_i2]) + r_buf[w_i7]
                       + small_sigma0_32(r_buf[w_i15]) + r_buf[w_i16];
        assign w_iv    = Mode ? IV224 : IV256;
    end else begin : g_w64
        assign w_k     = K512[r_t];
        assign w_sched = small_sigma1_64(r_buf[w_i2]) + r_buf[w_i7]
                       + small_sigma0_64(r_buf[w_i15]) + r_buf[w_i16];
        assign w_iv    = Mode ? IV384 : IV512;
    end

    assign w_w      = (r_t[6:4] == 3'd0) ? r_buf[w_i16] : w_sched;
    assign w_h_init = First ? w_iv : r_hash;

    sha_2_round #(
        .WIDTH (WIDTH)
    ) u_round (
        .i_state (r_work),
        .i_w     (w_w),
        .i_k     (w_k),
        .o_state (w_next)
    );

    for (genvar i = 0; i < 8; i++) begin : g_sum
        assign w_sum[i*WIDTH +: WIDTH] = r_work[i*WIDTH +: WIDTH] + r_chain[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_t         <= '0;
            r_work      <= '0;
            r_chain     <= '0;
            r_hash      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_chain    <= w_h_init;
                        r_work     <= w_h_init;
                        r_t        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRound;
                    end
                end
                StRound: begin
                    r_work <= w_next;
                    r_t    <= r_t + 7'd1;
                    if (r_t == LAST_T) begin
                        r_state <= StFinal;
                    end
                end
                StFinal: begin
                    r_hash      <= w_sum;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Schedule buffer contents are don't-care across reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= Data[i*WIDTH +: WIDTH];
            end
        end else if (r_state == StRound && r_t[6:4] != 3'd0) begin
            r_buf[w_i16] <= w_sched;
        end
    end

    assign In_ready  = r_in_ready;
    assign Out_valid = r_out_valid;
    assign Hash      = r_hash;

endmodule

// File: tb/tb_sha_2.sv
// Self-checking bench for sha_2: known-answer table, chaining/handshake/reset sequences,
// and random blocks against a textbook SHA-256/512 model.
module tb_sha_2;
    import sha_2_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [511:0]   d32;
    logic           f32, m32, v32, r32, ov32;
    logic [255:0]   h32;
    logic [1023:0]  d64;
    logic           f64, m64, v64, r64, ov64;
    logic [511:0]   h64;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha_2 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .Data(d32), .First(f32), .Mode(m32),
        .In_valid(v32), .In_ready(r32), .Hash(h32), .Out_valid(ov32)
    );

    sha_2 #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .Data(d64), .First(f64), .Mode(m64),
        .In_valid(v64), .In_ready(r64), .Hash(h64), .Out_valid(ov64)
    );

    typedef struct {
        string          name;
        bit             is64;
        bit             mode;
        logic [1023:0]  blk;
        logic [511:0]   exp;
        logic [511:0]   msk;
    } vec_t;

    localparam logic [255:0] ABC256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_BLK256 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[32*t +: 32];
            else w[t] = (ror32(w[t-2], 17) ^ ror32(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (ror32(w[t-15], 7) ^ ror32(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror32(v[4], 6) ^ ror32(v[4], 11) ^ ror32(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K256[t] + w[t];
            t2 = (ror32(v[0], 2) ^ ror32(v[0], 13) ^ ror32(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
        return r;
    endfunction

    function automatic logic [511:0] ref512(input logic [511:0] hin, input logic [1023:0] blk);
        logic [63:0]  w [80];
        logic [63:0]  v [8];
        logic [63:0]  t1, t2;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[511-64*i -: 64];
        for (int t = 0; t < 80; t++) begin
            if (t < 16) w[t] = blk[64*t +: 64];
            else w[t] = (ror64(w[t-2], 19) ^ ror64(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                      + (ror64(w[t-15], 1) ^ ror64(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
        end
        for (int t = 0; t < 80; t++) begin
            t1 = v[7] + (ror64(v[4], 14) ^ ror64(v[4], 18) ^ ror64(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K512[t] + w[t];
            t2 = (ror64(v[0], 28) ^ ror64(v[0], 34) ^ ror64(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[511-64*i -: 64] = v[i] + hin[511-64*i -: 64];
        return r;
    endfunction

    function automatic logic [511:0] iv_of(input bit is64, input bit mode);
        if (is64) return mode ? IV384 : IV512;
        return {256'b0, (mode ? IV224 : IV256)};
    endfunction

    function automatic logic [511:0] model(input bit is64, input logic [511:0] hin,
                                           input logic [1023:0] blk);
        if (is64) return ref512(hin, blk);
        return {256'b0, ref256(hin[255:0], blk[511:0])};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: offers a block, lets it be taken on the next posedge, then counts
    // negedges until Out_valid (lat=1 is the first negedge after the acceptance edge).
    task automatic run_blk(input bit is64, input logic [1023:0] blk, input bit first,
                           input bit mode, output logic [511:0] hash, output int lat,
                           output bit rdy);
        if (is64) begin
            d64 = blk; f64 = first; m64 = mode; v64 = 1'b1; rdy = r64;
        end else begin
            d32 = blk[511:0]; f32 = first; m32 = mode; v32 = 1'b1; rdy = r32;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            v32 = 1'b0;
            v64 = 1'b0;
        end while ((is64 ? ov64 : ov32) !== 1'b1 && lat < 200);
        hash = is64 ? h64 : {256'b0, h32};
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t          vecs [4];
    logic [1023:0] abc32, abc64, blk, blk2;
    logic [511:0]  hh, mexp, mh32, mh64;
    int            lat, pulses;
    bit            rdy, first, mode;

    initial begin
        rst = 1'b1;
        v32 = 1'b0; f32 = 1'b0; m32 = 1'b0; d32 = '0;
        v64 = 1'b0; f64 = 1'b0; m64 = 1'b0; d64 = '0;
        mh32 = '0;
        mh64 = '0;

        abc32 = '0;
        abc32[31:0] = 32'h61626380;
        abc32[15*32 +: 32] = 32'h18;
        abc64 = '0;
        abc64[63:0] = 64'h6162638000000000;
        abc64[15*64 +: 64] = 64'h18;

        vecs[0] = '{"abc-256", 1'b0, 1'b0, abc32, {256'b0, ABC256}, {256'b0, {256{1'b1}}}};
        vecs[1] = '{"abc-224", 1'b0, 1'b1, abc32,
                    {256'b0, 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7,
                     32'b0},
                    {256'b0, {224{1'b1}}, 32'b0}};
        vecs[2] = '{"abc-512", 1'b1, 1'b0, abc64,
                    {128'hddaf35a193617abacc417349ae204131, 384'b0}, {{128{1'b1}}, 384'b0}};
        vecs[3] = '{"abc-384", 1'b1, 1'b1, abc64,
                    {128'hcb00753f45a35e8bb5a03d699ac65007, 384'b0}, {{128{1'b1}}, 384'b0}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/ready32", 512'(r32), 512'(1'b1));
        check("reset/valid32", 512'(ov32), 512'(1'b0));
        check("reset/hash32", {256'b0, h32}, '0);
        check("reset/ready64", 512'(r64), 512'(1'b1));
        check("reset/valid64", 512'(ov64), 512'(1'b0));
        check("reset/hash64", h64, '0);

        foreach (vecs[i]) begin
            run_blk(vecs[i].is64, vecs[i].blk, 1'b1, vecs[i].mode, hh, lat, rdy);
            mexp = model(vecs[i].is64, iv_of(vecs[i].is64, vecs[i].mode), vecs[i].blk);
            check({vecs[i].name, "/ready"}, 512'(rdy), 512'(1'b1));
            check({vecs[i].name, "/digest"}, hh & vecs[i].msk, vecs[i].exp);
            check({vecs[i].name, "/model"}, hh, mexp);
            check({vecs[i].name, "/latency"}, 512'(lat), 512'((vecs[i].is64 ? 80 : 64) + 2));
            if (vecs[i].is64) mh64 = mexp;
            else mh32 = mexp;
        end

        // Two-block message, second block offered in the Out_valid cycle.
        blk = '0;
        for (int i = 0; i < 14; i++) begin
            blk[32*i +: 32] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
        end
        blk[14*32 +: 32] = 32'h80000000;
        blk2 = '0;
        blk2[15*32 +: 32] = 32'h000001c0;
        run_blk(1'b0, blk, 1'b1, 1'b0, hh, lat, rdy);
        mh32 = model(1'b0, iv_of(1'b0, 1'b0), blk);
        check("2blk/first_model", hh, mh32);
        run_blk(1'b0, blk2, 1'b0, 1'b0, hh, lat, rdy);
        check("2blk/ready_in_out_valid_cycle", 512'(rdy), 512'(1'b1));
        check("2blk/digest", hh, {256'b0, TWO_BLK256});
        check("2blk/latency", 512'(lat), 512'(66));
        mh32 = {256'b0, TWO_BLK256};

        // In_valid held with new Data/Mode while busy: must not disturb the running block.
        d32 = abc32[511:0]; f32 = 1'b1; m32 = 1'b0; v32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
        d32 = blk[511:0];
        m32 = 1'b1;
        lat = 1;
        while (ov32 !== 1'b1 && lat < 200) begin
            if (lat == 20) begin
                check("hold/busy_ready", 512'(r32), 512'(1'b0));
                check("hold/hash_stable", {256'b0, h32}, mh32);
            end
            @(negedge clk);
            lat++;
        end
        check("hold/first_digest", {256'b0, h32}, {256'b0, ABC256});
        check("hold/first_latency", 512'(lat), 512'(66));
        run_blk(1'b0, blk, 1'b1, 1'b1, hh, lat, rdy);
        check("hold/second_ready", 512'(rdy), 512'(1'b1));
        check("hold/second_digest", hh, model(1'b0, iv_of(1'b0, 1'b1), blk));
        check("hold/second_latency", 512'(lat), 512'(66));

        // Reset around round 30 abandons the block.
        d32 = abc32[511:0]; f32 = 1'b1; m32 = 1'b0; v32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/ready", 512'(r32), 512'(1'b1));
        check("midrst/hash", {256'b0, h32}, '0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (ov32 === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midrst/no_out_valid", 512'(pulses), '0);
        run_blk(1'b0, abc32, 1'b1, 1'b0, hh, lat, rdy);
        check("midrst/abc_digest", hh, {256'b0, ABC256});

        // Reset and In_valid together: reset wins.
        for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
        d32 = blk[511:0]; f32 = 1'b1; m32 = 1'b0; v32 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v32 = 1'b0;
        check("rstwin/ready", 512'(r32), 512'(1'b1));
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (ov32 === 1'b1) pulses++;
            @(negedge clk);
        end
        check("rstwin/no_out_valid", 512'(pulses), '0);
        check("rstwin/hash", {256'b0, h32}, '0);
        mh32 = '0;
        mh64 = '0;

        // Random chained blocks; first of each run uses First=0 to chain from the zero Hash.
        for (int k = 0; k < 12; k++) begin
            bit is64;
            is64 = (k >= 6);
            for (int j = 0; j < 32; j++) blk[32*j +: 32] = $urandom();
            first = (k == 0 || k == 6) ? 1'b0 : 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            mexp = model(is64, first ? iv_of(is64, mode) : (is64 ? mh64 : mh32), blk);
            run_blk(is64, blk, first, mode, hh, lat, rdy);
            check($sformatf("rand%0d/digest", k), hh, mexp);
            check($sformatf("rand%0d/latency", k), 512'(lat), 512'(is64 ? 82 : 66));
            if (is64) mh64 = mexp;
            else mh32 = mexp;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
